// File: rtl/bcd_seg7_pkg.sv
// Shared constants and helpers for the BCD up/down counter with 7-segment driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_seg7_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    // Decimal-only decode; codes above 9 never reach the display and go blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Clamp a loaded nibble into the BCD range.
    function automatic logic [3:0] bcd_sat(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain: load, increment with carry, decrement with borrow.
module bcd_digit
    import bcd_seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       carry_out,
    output logic       borrow_out
);

    logic [3:0] q_d, q_q;

    // Next digit value: load wins over count, 9 wraps to 0 up, 0 wraps to 9 down.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = bcd_sat(ld_val);
        end else if (inc) begin
            q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
        end else if (dec) begin
            q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q          = q_q;
    assign carry_out  = inc & (q_q == BCD_MAX);
    assign borrow_out = dec & (q_q == 4'd0);

endmodule

// File: rtl/bcd_updown_counter_seg7.sv
// N-digit BCD up/down counter with clock-enable prescaler and multiplexed 7-segment driver.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks digits above the most-significant
// nonzero digit (digit 0 is always shown).
module bcd_updown_counter_seg7
    import bcd_seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 8,
    parameter int unsigned PRESC_W   = 27,
    parameter int unsigned REFRESH_W = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    En,
    input  logic                    dir,
    input  logic [4:0]              s,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   load_val,
    output logic [4*N_DIGITS-1:0]   cnt_out,
    output logic                    tc,
    output logic [6:0]              Cnode,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     AN
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned S_MAX = PRESC_W - 1;
    localparam logic [N_DIGITS-1:0] AN_RST = ~N_DIGITS'(1);

    logic [PRESC_W-1:0]   presc_d, presc_q;
    logic [4:0]           s_d, s_q;
    logic [REFRESH_W-1:0] refresh_d, refresh_q;
    logic [IDX_W-1:0]     idx_d, idx_q;
    logic                 tc_d, tc_q;
    logic [N_DIGITS-1:0]  an_d, an_q;
    logic [6:0]           cnode_d, cnode_q;
    logic                 dp_d, dp_q;

    logic                 tick;
    int unsigned          s_eff;
    logic [3:0]           sel_nib;
    logic                 blank;
`ifdef LEADING_ZERO_BLANK_EN
    logic                 zero_above;
`endif

    logic [N_DIGITS-1:0]  inc, dec, carry, borrow;

    // Rate tick: the low s'+1 prescaler bits are all ones, s' clamped to the prescaler width.
    always_comb begin
        s_eff = (32'(s_q) > S_MAX) ? S_MAX : 32'(s_q);
        tick  = 1'b1;
        for (int unsigned i = 0; i < PRESC_W; i++) begin
            if (i <= s_eff && !presc_q[i]) tick = 1'b0;
        end
    end

    // Count enables enter at digit 0 and ripple up through carry/borrow.
    assign inc[0] = tick & En & dir  & ~load;
    assign dec[0] = tick & En & ~dir & ~load;

    for (genvar g = 1; g < N_DIGITS; g++) begin : g_chain
        assign inc[g] = carry[g-1];
        assign dec[g] = borrow[g-1];
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .inc        (inc[g]),
            .dec        (dec[g]),
            .load       (load),
            .ld_val     (load_val[4*g +: 4]),
            .q          (cnt_out[4*g +: 4]),
            .carry_out  (carry[g]),
            .borrow_out (borrow[g])
        );
    end

    // Next-state for prescaler, refresh scan, wrap flag and display output registers.
    always_comb begin
        presc_d   = presc_q + PRESC_W'(1);
        s_d       = s;
        refresh_d = refresh_q + REFRESH_W'(1);
        idx_d     = idx_q;
        if (refresh_q == '1) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        // A carry or borrow out of the top digit is exactly an all-9s / all-0s wrap.
        tc_d = carry[N_DIGITS-1] | borrow[N_DIGITS-1];

        sel_nib = 4'd0;
        an_d    = '1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nib = cnt_out[4*i +: 4];
                an_d[i] = 1'b0;
            end
        end

        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        zero_above = 1'b1;
        for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (cnt_out[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i) && zero_above) blank = 1'b1;
        end
`endif

        cnode_d = blank ? SEG_BLANK : seg_decode(sel_nib);
        dp_d    = ~((idx_q == '0) & ~dir);
    end

    // All top-level registers; AN, Cnode and dp share one clock edge so they never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            s_q       <= '0;
            refresh_q <= '0;
            idx_q     <= '0;
            tc_q      <= 1'b0;
            an_q      <= AN_RST;
            cnode_q   <= SEG_DIGIT[0];
            dp_q      <= 1'b1;
        end else begin
            presc_q   <= presc_d;
            s_q       <= s_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            tc_q      <= tc_d;
            an_q      <= an_d;
            cnode_q   <= cnode_d;
            dp_q      <= dp_d;
        end
    end

    assign tc    = tc_q;
    assign AN    = an_q;
    assign Cnode = cnode_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_bcd_updown_counter_seg7.sv
// Self-checking bench for bcd_updown_counter_seg7 (N_DIGITS=4, PRESC_W=8, REFRESH_W=2).
// The reference model keeps the count as a plain integer 0..9999 and the display scan as
// cycle arithmetic; directed literal checks pin the model, then random stimulus runs.
module tb_bcd_updown_counter_seg7;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst, En, dir, load;
    logic [4:0]  s;
    logic [15:0] load_val;
    logic [15:0] cnt_out;
    logic        tc, dp;
    logic [6:0]  Cnode;
    logic [3:0]  AN;

    int errors = 0;
    int checks = 0;
    int tc_seen = 0;

    bcd_updown_counter_seg7 #(.N_DIGITS(4), .PRESC_W(8), .REFRESH_W(2)) dut (
        .clk(clk), .rst(rst), .En(En), .dir(dir), .s(s), .load(load),
        .load_val(load_val), .cnt_out(cnt_out), .tc(tc), .Cnode(Cnode), .dp(dp), .AN(AN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int p10(input int i);
        int r = 1;
        for (int k = 0; k < i; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
        return r;
    endfunction

    function automatic int from_bcd_sat(input logic [15:0] b);
        int r = 0;
        int d;
        for (int i = 0; i < ND; i++) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            r = r + d * p10(i);
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int v, input int i);
        int d = (v / p10(i)) % 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && v < p10(i)) return 7'b1111111;
`endif
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Tick fires when prescaler value modulo the rate period is the last count of the period.
    function automatic bit tick_of(input int presc, input int sq);
        int sp = (sq > 7) ? 7 : sq;
        int per = 1 << (sp + 1);
        return (presc % per) == (per - 1);
    endfunction

    // Reference model state, advanced on every rising edge.
    int         m_val, m_presc, m_ref, m_idx, m_sq;
    logic [3:0] m_an;
    logic [6:0] m_cn;
    logic       m_dp, m_tc;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin : model
        int nv;
        bit ntc;
        bit tk;
        logic [3:0] one;
        one = 4'b0001;
        if (rst) begin
            m_val <= 0; m_presc <= 0; m_ref <= 0; m_idx <= 0; m_sq <= 0;
            m_an <= 4'b1110; m_cn <= 7'b1000000; m_dp <= 1'b1; m_tc <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            tk  = tick_of(m_presc, m_sq);
            m_an <= ~(one << m_idx);
            m_cn <= seg_of(m_val, m_idx);
            m_dp <= !(m_idx == 0 && dir == 1'b0);
            nv  = m_val;
            ntc = 1'b0;
            if (load) begin
                nv = from_bcd_sat(load_val);
            end else if (tk && En) begin
                if (dir) begin
                    if (m_val == p10(ND) - 1) begin nv = 0; ntc = 1'b1; end
                    else nv = m_val + 1;
                end else begin
                    if (m_val == 0) begin nv = p10(ND) - 1; ntc = 1'b1; end
                    else nv = m_val - 1;
                end
            end
            m_val   <= nv;
            m_tc    <= ntc;
            m_presc <= (m_presc + 1) % 256;
            m_ref   <= (m_ref + 1) % 4;
            if (m_ref == 3) m_idx <= (m_idx + 1) % ND;
            m_sq    <= int'(s);
        end
    end

    // Every cycle after the first reset: all outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cnt_out", 32'(cnt_out), 32'(to_bcd(m_val)));
            chk("tc",      32'(tc),      32'(m_tc));
            chk("AN",      32'(AN),      32'(m_an));
            chk("Cnode",   32'(Cnode),   32'(m_cn));
            chk("dp",      32'(dp),      32'(m_dp));
        end
    end

    always @(posedge clk) begin
        #1;
        if (tc === 1'b1) tc_seen++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_val = v;
        step();
        load = 1'b0;
    endtask

    task automatic wait_cnt(input logic [15:0] v, input string nm);
        logic found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cnt_out === v) begin found = 1'b1; break; end
            step();
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    initial begin
        int base;
        logic found;
        logic stable;
        int changes;
        logic [15:0] prev_cnt;
        logic [3:0] prev_an;
        logic [6:0] cn_d2;

        rst = 1'b1; En = 1'b0; dir = 1'b1; load = 1'b0; s = 5'd0; load_val = '0;
        step(); step();
        chk("rst_cnt",   32'(cnt_out), 32'h0);
        chk("rst_tc",    32'(tc),      32'd0);
        chk("rst_AN",    32'(AN),      32'b1110);
        chk("rst_Cnode", 32'(Cnode),   32'b1000000);
        chk("rst_dp",    32'(dp),      32'd1);
        rst = 1'b0;

        // 0998 counts up through 0999 into 1000 without a terminal count.
        En = 1'b1; dir = 1'b1; s = 5'd0;
        do_load(16'h0998);
        base = tc_seen;
        wait_cnt(16'h1000, "reach_1000");
        chk("no_tc_1000", 32'(tc_seen - base), 32'd0);

        // All-9s wraps to 0000 with a one-cycle tc.
        do_load(16'h9999);
        base = tc_seen;
        wait_cnt(16'h0000, "wrap_up");
        chk("tc_wrap_up", 32'(tc), 32'd1);
        step();
        chk("tc_drop_up", 32'(tc), 32'd0);
        chk("tc_once_up", 32'(tc_seen - base), 32'd1);

        // All-0s wraps down to 9999; dp low while digit 0 is scanned.
        dir = 1'b0;
        do_load(16'h0000);
        base = tc_seen;
        wait_cnt(16'h9999, "wrap_down");
        chk("tc_wrap_dn", 32'(tc), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (AN === 4'b1110) begin found = 1'b1; break; end
            step();
        end
        chk("an0_seen", 32'(found), 32'd1);
        chk("dp_down",  32'(dp), 32'd0);

        // Load coinciding with a tick: saturated load, no increment, no tc.
        dir = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tick_of(m_presc, m_sq)) begin found = 1'b1; break; end
            step();
        end
        chk("tick_found", 32'(found), 32'd1);
        load = 1'b1; load_val = 16'h12F4;
        step();
        load = 1'b0; En = 1'b0;
        chk("load_sat", 32'(cnt_out), 32'h1294);
        chk("load_notc", 32'(tc), 32'd0);

        // Frozen count while the scan keeps running.
        do_load(16'h0042);
        chk("load_42", 32'(cnt_out), 32'h0042);
        prev_cnt = cnt_out; prev_an = AN; stable = 1'b1; changes = 0; cn_d2 = 7'h00;
        for (int i = 0; i < 64; i++) begin
            step();
            if (cnt_out !== prev_cnt) stable = 1'b0;
            if (AN !== prev_an) changes++;
            prev_an = AN;
            if (AN === 4'b1011) cn_d2 = Cnode;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        chk("scan_changes", 32'(changes), 32'd16);
`ifdef LEADING_ZERO_BLANK_EN
        chk("digit2_blank", 32'(cn_d2), 32'b1111111);
`else
        chk("digit2_zero", 32'(cn_d2), 32'b1000000);
`endif

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            load = ($urandom_range(0, 19) == 0);
            load_val = 16'($urandom);
            if ($urandom_range(0, 3) == 0) load_val = ($urandom_range(0, 1) == 0) ? 16'h9999 : 16'h0000;
            En   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) dir = ~dir;
            if ($urandom_range(0, 49) == 0) s = 5'($urandom_range(0, 9));
            if (i < 1500 && s > 5'd2) s = 5'd0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
